// File: rtl/effect_pkg.sv
// Shared constants, state encoding and helpers for the compressor stage.
package effect_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENV   = 2'd1,
        S_DIV   = 2'd2,
        S_APPLY = 2'd3
    } state_t;

    localparam logic [15:0] GAIN_UNITY = 16'h8000;

    // Threshold per i_level; level 0 sits at full scale so nothing compresses.
    localparam logic [15:0] THRESH [8] = '{
        16'd32767, 16'd24576, 16'd16384, 16'd12288,
        16'd8192,  16'd6144,  16'd4096,  16'd2048
    };

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767)
            return 16'sh7fff;
        else if (v < -17'sd32768)
            return 16'sh8000;
        else
            return 16'(v);
    endfunction

endpackage

// File: rtl/serial_divider_u16.sv
// Restoring divider, one quotient bit per cycle MSB first, 16 cycles per result.
// Requires dividend[30:16] < divisor so the quotient fits in 16 bits.
module serial_divider_u16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [30:0] dividend,
    input  logic [15:0] divisor,
    output logic        done,
    output logic [15:0] quotient
);

    logic        busy;
    logic [3:0]  cnt;
    logic [15:0] rem;
    logic [15:0] dvd_lo;
    logic [15:0] dvs;
    logic [16:0] shifted;
    logic [16:0] diff;
    logic        q_bit;

    always_comb begin
        shifted = {rem, dvd_lo[15]};
        diff    = shifted - {1'b0, dvs};
        q_bit   = (shifted >= {1'b0, dvs});
        // done marks the final iteration; quotient is complete from the next cycle
        done    = busy && (cnt == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            cnt      <= 4'd0;
            rem      <= 16'd0;
            dvd_lo   <= 16'd0;
            dvs      <= 16'd0;
            quotient <= 16'd0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= 4'd15;
            rem      <= {1'b0, dividend[30:16]};
            dvd_lo   <= dividend[15:0];
            dvs      <= divisor;
            quotient <= 16'd0;
        end else if (busy) begin
            rem      <= q_bit ? 16'(diff) : 16'(shifted);
            dvd_lo   <= {dvd_lo[14:0], 1'b0};
            quotient <= {quotient[14:0], q_bit};
            cnt      <= cnt - 4'd1;
            if (cnt == 4'd0)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/effect_compressor.sv
// Per-sample dynamic-range compressor: envelope follower, serial gain divide, apply.
// state   | meaning
// S_IDLE  | waiting for i_valid; captures sample and controls
// S_ENV   | envelope update, threshold compare, divider start
// S_DIV   | 16 cycles of gain division
// S_APPLY | multiply by gain (or bypass), publish o_data/o_valid
module effect_compressor
    import effect_pkg::*;
#(
    parameter int unsigned ATTACK_SHIFT  = 2,
    parameter int unsigned RELEASE_SHIFT = 8,
    parameter int unsigned RATIO_SHIFT   = 2
) (
    input  logic        i_AUD_BCLK,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_enable,
    input  logic [2:0]  i_level,
    input  logic [15:0] i_data,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_busy,
    output logic        o_overrun
);

    state_t      state;
    logic [15:0] x_r;
    logic        en_r;
    logic [2:0]  lvl_r;
    logic [15:0] env;
    logic        unity;

    logic [16:0] x_ext;
    logic [15:0] abs_x;
    logic [15:0] env_next;
    logic [15:0] thr;
    logic [15:0] target_next;
    logic        unity_next;
    logic        div_done;
    logic [15:0] quotient;
    logic [15:0] gain;
    logic [32:0] prod;
    logic [15:0] y;

    always_comb begin
        x_ext = {x_r[15], x_r};
        // -32768 has no positive twin; sat16 clamps its magnitude to 32767
        abs_x = sat16(x_r[15] ? -x_ext : x_ext);

        env_next = env;
        if (abs_x > env)
            env_next = env + ((abs_x - env) >> ATTACK_SHIFT);
        else if (abs_x < env)
            env_next = env - ((env - abs_x) >> RELEASE_SHIFT);

        thr         = THRESH[lvl_r];
        unity_next  = (env_next <= thr);
        target_next = thr + ((env_next - thr) >> RATIO_SHIFT);

        gain = unity ? GAIN_UNITY : quotient;
        prod = {{17{x_r[15]}}, x_r} * {17'd0, gain};
        y    = 16'($signed(prod) >>> 15);
    end

    serial_divider_u16 u_div (
        .clk      (i_AUD_BCLK),
        .rst_n    (i_rst_n),
        .start    (state == S_ENV),
        .dividend ({target_next, 15'd0}),
        .divisor  (env_next),
        .done     (div_done),
        .quotient (quotient)
    );

    assign o_busy = (state != S_IDLE);

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            x_r       <= 16'd0;
            en_r      <= 1'b0;
            lvl_r     <= 3'd0;
            env       <= 16'd0;
            unity     <= 1'b1;
            o_data    <= 16'd0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_valid && state != S_IDLE)
                o_overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        x_r   <= i_data;
                        en_r  <= i_enable;
                        lvl_r <= i_level;
                        state <= S_ENV;
                    end
                end
                S_ENV: begin
                    env   <= env_next;
                    unity <= unity_next;
                    state <= S_DIV;
                end
                S_DIV: begin
                    if (div_done)
                        state <= S_APPLY;
                end
                S_APPLY: begin
                    o_data  <= en_r ? y : x_r;
                    o_valid <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_effect_compressor.sv
// Self-checking bench for effect_compressor: arithmetic reference model plus directed and random samples.
module tb_effect_compressor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_enable = 1'b0;
    logic [2:0]  i_level = 3'd0;
    logic [15:0] i_data = 16'd0;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_busy;
    logic        o_overrun;

    effect_compressor dut (
        .i_AUD_BCLK (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .i_enable   (i_enable),
        .i_level    (i_level),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int due;
        int y;
    } exp_t;
    exp_t q[$];

    int thr_tab [8] = '{32767, 24576, 16384, 12288, 8192, 6144, 4096, 2048};
    int m_env  = 0;
    bit m_ovr  = 0;
    int m_free = 0;
    int m_acc  = -100;

    int last_out  = 0;
    int last_vcyc = 0;
    int n_valid   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_sample(input int x, input bit en, input int lvl);
        int a, thr, tgt, gain;
        longint p;
        a = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        if (a > m_env)      m_env = m_env + ((a - m_env) >> 2);
        else if (a < m_env) m_env = m_env - ((m_env - a) >> 8);
        thr = thr_tab[lvl];
        if (m_env > thr) begin
            tgt  = thr + ((m_env - thr) >> 2);
            gain = (tgt * 32768) / m_env;
        end else begin
            gain = 32768;
        end
        if (!en) return x;
        p = longint'(x) * gain;
        return int'(p >>> 15);
    endfunction

    // Reference model: reacts to the inputs only, one result 19 cycles after each accepted sample.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_env  = 0;
            m_ovr  = 0;
            m_free = 0;
            m_acc  = -100;
            q.delete();
        end else if (i_valid) begin
            if (cyc >= m_free) begin
                int yv;
                yv = model_sample(int'($signed(i_data)), i_enable, int'(i_level));
                q.push_back('{cyc + 19, yv});
                m_free = cyc + 19;
                m_acc  = cyc;
            end else begin
                m_ovr = 1;
            end
        end
    end

    // Compare process: every cycle out of reset.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            bit ev;
            ev = (q.size() > 0) && (q[0].due == cyc);
            check("valid", longint'(o_valid), longint'(ev));
            if (ev) begin
                if (o_valid) check("data", longint'($signed(o_data)), longint'(q[0].y));
                void'(q.pop_front());
            end
            if (o_valid) begin
                last_out  = int'($signed(o_data));
                last_vcyc = cyc;
                n_valid++;
            end
            check("busy", longint'(o_busy), longint'((cyc > m_acc) && (cyc <= m_acc + 18)));
            check("overrun", longint'(o_overrun), longint'(m_ovr));
        end
    end

    task automatic pulse(input int x, input bit en, input int lvl);
        i_data   = 16'(x);
        i_enable = en;
        i_level  = 3'(lvl);
        i_valid  = 1'b1;
        @(negedge clk);
        i_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int nv0;
        idle(3);
        #2 rst_n = 1'b1;
        idle(1);
        check("rst_data", longint'(o_data), 0);
        check("rst_valid", longint'(o_valid), 0);
        check("rst_busy", longint'(o_busy), 0);
        check("rst_overrun", longint'(o_overrun), 0);

        // Produce a nonzero output, then reset while the divider is running.
        pulse(20000, 1, 0);
        idle(19);
        check("pre_rst_out", last_out, 20000);
        pulse(1000, 1, 3);
        idle(8);
        check("busy_in_div", longint'(o_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_data", longint'(o_data), 0);
        check("abort_valid", longint'(o_valid), 0);
        check("abort_busy", longint'(o_busy), 0);
        check("abort_overrun", longint'(o_overrun), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        pulse(500, 1, 0);
        idle(19);
        check("post_rst_out", last_out, 500);
        check("post_rst_lat", last_vcyc - m_acc, 19);

        // Level 0: no compression.
        repeat (4) begin
            pulse(20000, 1, 0);
            idle(63);
            check("lvl0_out", last_out, 20000);
            check("lvl0_lat", last_vcyc - m_acc, 19);
        end

        // Level 4 settled at +/-16384.
        do_reset();
        repeat (64) begin
            pulse(16384, 1, 4);
            idle(20);
        end
        check("t3_env_range", longint'(m_env >= 16381 && m_env <= 16384), 1);
        check("t3_pos", longint'(last_out >= 10238 && last_out <= 10242), 1);
        repeat (8) begin
            pulse(-16384, 1, 4);
            idle(20);
        end
        check("t3_neg", longint'(last_out >= -10242 && last_out <= -10238), 1);

        // Bypass at level 7.
        repeat (64) begin
            pulse(30000, 0, 7);
            idle(20);
        end
        check("bypass_out", last_out, 30000);
        check("bypass_lat", last_vcyc - m_acc, 19);

        // Overrun: second i_valid 5 cycles after the first.
        do_reset();
        nv0 = n_valid;
        pulse(1234, 1, 0);
        idle(4);
        pulse(999, 1, 0);
        idle(20);
        check("ovr_flag", longint'(o_overrun), 1);
        check("ovr_nvalid", n_valid - nv0, 1);
        check("ovr_first_out", last_out, 1234);

        // i_valid in the o_valid cycle is accepted.
        do_reset();
        nv0 = n_valid;
        pulse(111, 1, 0);
        idle(18);
        pulse(222, 1, 0);
        idle(20);
        check("coinc_overrun", longint'(o_overrun), 0);
        check("coinc_nvalid", n_valid - nv0, 2);
        check("coinc_out", last_out, 222);

        // Full-scale negative input at level 0.
        do_reset();
        pulse(-32768, 1, 0);
        idle(19);
        check("neg_fullscale", last_out, -32768);

        // Randomized traffic, including overruns and back-to-back acceptance.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            int x, r;
            x = int'($signed(16'($urandom)));
            r = int'($urandom_range(0, 7));
            if (r == 0) x = -32768;
            else if (r == 1) x = 32767;
            else if (r == 2) x = int'($urandom_range(0, 400)) - 200;
            pulse(x, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)));
            i_data   = 16'($urandom);
            i_enable = 1'($urandom);
            i_level  = 3'($urandom);
            r = int'($urandom_range(0, 9));
            if (r == 0)      idle(18);
            else if (r == 1) idle(int'($urandom_range(0, 17)));
            else             idle(int'($urandom_range(19, 60)));
        end
        idle(25);
        check("drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
